// File: rtl/cdc_send_arbiter.sv
// Round-robin front end for a shared CDC sender channel: one transfer in flight,
// released by the returning ack (then an idle gap) or by the ack watchdog.
module cdc_send_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 4,
  parameter int TMO_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          grant,
  output logic [DATA_W-1:0]         data,
  output logic                      en,
  input  logic                      ack,
  input  logic [7:0]                gap,
  input  logic [TMO_W-1:0]          tmo_limit,
  output logic                      busy,
  output logic                      tmo_err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    GAP      = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_q, rr_d;
  logic [7:0]          gap_cnt_q, gap_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                en_q, en_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q;
  logic                tmo_err_s;

  logic [DATA_W-1:0]   pay_s [N_REQ];
  logic [PTR_W-1:0]    idx_s;
  logic [PTR_W-1:0]    sel_s;
  logic                hit_s;

  for (genvar i = 0; i < N_REQ; i++) begin : g_pay
    assign pay_s[i] = req_data[i*DATA_W +: DATA_W];
  end

  // First requesting index at or after the round-robin pointer, with wrap-around.
  always_comb begin
    sel_s = {PTR_W{1'b0}};
    hit_s = 1'b0;
    idx_s = {PTR_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = PTR_W'((int'(rr_q) + k) % N_REQ);
      if (!hit_s && req[idx_s]) begin
        hit_s = 1'b1;
        sel_s = idx_s;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Next-state logic; the ack in the en cycle is ignored and ack beats a same-cycle expiry.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gap_cnt_d = gap_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    en_d      = 1'b0;
    grant_d   = {N_REQ{1'b0}};
    data_d    = data_q;
    tmo_err_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit_s) begin
          en_d      = 1'b1;
          grant_d   = {{(N_REQ-1){1'b0}}, 1'b1} << sel_s;
          data_d    = pay_s[sel_s];
          rr_d      = (sel_s == PTR_W'(N_REQ - 1)) ? {PTR_W{1'b0}} : sel_s + PTR_W'(1);
          tmo_cnt_d = {TMO_W{1'b0}};
          state_d   = WAIT_ACK;
        end else begin
          state_d   = IDLE;
        end
      end
      WAIT_ACK: begin
        if (ack && !en_q) begin
          gap_cnt_d = gap;
          tmo_cnt_d = {TMO_W{1'b0}};
          state_d   = (gap == 8'd0) ? IDLE : GAP;
        end else if (tmo_limit != {TMO_W{1'b0}}) begin
          if (tmo_cnt_q >= tmo_limit) begin
            tmo_err_s = 1'b1;
            tmo_cnt_d = {TMO_W{1'b0}};
            state_d   = IDLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q;
        end
      end
      GAP: begin
        if (gap_cnt_q <= 8'd1) begin
          gap_cnt_d = 8'd0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= {PTR_W{1'b0}};
      gap_cnt_q <= 8'd0;
      tmo_cnt_q <= {TMO_W{1'b0}};
      en_q      <= 1'b0;
      grant_q   <= {N_REQ{1'b0}};
      data_q    <= {DATA_W{1'b0}};
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gap_cnt_q <= gap_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      en_q      <= en_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign en      = en_q;
  assign grant   = grant_q;
  assign data    = data_q;
  assign busy    = busy_q;
  // Combinational so that an ack arriving on the expiry cycle can suppress it.
  assign tmo_err = tmo_err_s;

endmodule

// File: tb/tb_cdc_send_arbiter.sv
// Directed bench for cdc_send_arbiter: latencies, round-robin order, watchdog, reset abort.
module tb_cdc_send_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [15:0] req_data = 16'h0000;
  logic [3:0]  grant;
  logic [3:0]  data;
  logic        en;
  logic        ack = 1'b0;
  logic [7:0]  gap = 8'd0;
  logic [7:0]  tmo_limit = 8'd0;
  logic        busy;
  logic        tmo_err;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] exp_d [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};

  cdc_send_arbiter #(.N_REQ(4), .DATA_W(4), .TMO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .grant(grant), .data(data), .en(en), .ack(ack), .gap(gap),
    .tmo_limit(tmo_limit), .busy(busy), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!en && cnt < 60);
    if (!en) check_eq("en_wait_budget", 32'(cnt), 32'd0);
  endtask

  // Called in the en cycle: drop requests, ack one cycle later, back to IDLE with gap 0.
  task automatic close_xfer();
    req = 4'b0000;
    gap = 8'd0;
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    // Reset state
    #3;
    check_eq("rst_en", en, 1'b0);
    check_eq("rst_grant", grant, 4'b0000);
    check_eq("rst_data", data, 4'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_tmo_err", tmo_err, 1'b0);
    step();
    rst_n = 1'b1;

    // Single requester, gap 3, ack 5 cycles after en
    gap = 8'd3;
    req_data = 16'h0007;
    req = 4'b0001;
    wait_en(n);
    check_eq("t1_lat", 32'(n), 32'd1);
    check_eq("t1_grant", grant, 4'b0001);
    check_eq("t1_data", data, 4'h7);
    check_eq("t1_busy", busy, 1'b1);
    req = 4'b0000;
    req_data = 16'h0009;
    repeat (4) step();
    check_eq("t1_wait_en", en, 1'b0);
    check_eq("t1_wait_data", data, 4'h7);
    step();
    ack = 1'b1;
    req = 4'b0001;
    step();
    ack = 1'b0;
    check_eq("t1_gap_data", data, 4'h7);
    check_eq("t1_gap_busy", busy, 1'b1);
    wait_en(n);
    check_eq("t1_gap_lat", 32'(n + 1), 32'd5);
    check_eq("t1_data2", data, 4'h9);
    check_eq("t1_grant2", grant, 4'b0001);
    close_xfer();
    check_eq("t1_idle_busy", busy, 1'b0);

    // Round-robin order with all requesters held, gap 0, ack 2 cycles after en
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_data = 16'hDCBA;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_en(n);
      check_eq("t2_lat", 32'(n), 32'd1);
      check_eq("t2_grant", grant, exp_g[k]);
      check_eq("t2_data", data, exp_d[k]);
      step();
      step();
      ack = 1'b1;
      step();
      ack = 1'b0;
    end
    req = 4'b0000;

    // Pointer at 3 after a grant to 2; lone req[1] wins, then {0,2} picks 2
    req = 4'b0100;
    wait_en(n);
    check_eq("t3_grant_a", grant, 4'b0100);
    close_xfer();
    req = 4'b0010;
    wait_en(n);
    check_eq("t3_grant_b", grant, 4'b0010);
    check_eq("t3_data_b", data, 4'hB);
    close_xfer();
    req = 4'b0101;
    wait_en(n);
    check_eq("t3_grant_c", grant, 4'b0100);
    check_eq("t3_data_c", data, 4'hC);
    close_xfer();

    // Watchdog 10, no ack; late ack ignored; next request served normally
    tmo_limit = 8'd10;
    req = 4'b0001;
    wait_en(n);
    check_eq("t4_grant", grant, 4'b0001);
    req = 4'b0000;
    repeat (9) step();
    check_eq("t4_pre_tmo", tmo_err, 1'b0);
    step();
    check_eq("t4_tmo_pulse", tmo_err, 1'b1);
    step();
    check_eq("t4_tmo_width", tmo_err, 1'b0);
    check_eq("t4_busy_drop", busy, 1'b0);
    step();
    step();
    ack = 1'b1;
    #1;
    check_eq("t4_late_ack_tmo", tmo_err, 1'b0);
    step();
    ack = 1'b0;
    check_eq("t4_late_ack_busy", busy, 1'b0);
    check_eq("t4_late_ack_en", en, 1'b0);
    req = 4'b0100;
    wait_en(n);
    check_eq("t4_next_lat", 32'(n), 32'd1);
    check_eq("t4_next_grant", grant, 4'b0100);
    close_xfer();

    // Watchdog 4 with ack on the expiry cycle: ack wins, GAP of 2
    tmo_limit = 8'd4;
    gap = 8'd2;
    req = 4'b1000;
    wait_en(n);
    check_eq("t5_grant", grant, 4'b1000);
    req = 4'b0000;
    repeat (4) step();
    ack = 1'b1;
    #1;
    check_eq("t5_ack_wins", tmo_err, 1'b0);
    step();
    ack = 1'b0;
    check_eq("t5_gap_busy", busy, 1'b1);
    check_eq("t5_gap_tmo", tmo_err, 1'b0);
    step();
    step();
    check_eq("t5_gap_done", busy, 1'b0);
    gap = 8'd0;
    req = 4'b0001;
    wait_en(n);
    check_eq("t5_grant2", grant, 4'b0001);
    req = 4'b0000;
    repeat (4) step();
    check_eq("t5_tmo_pulse", tmo_err, 1'b1);
    req = 4'b0010;
    wait_en(n);
    check_eq("t5_after_tmo_lat", 32'(n), 32'd2);
    check_eq("t5_after_tmo_grant", grant, 4'b0010);
    close_xfer();

    // Reset during WAIT_ACK (in the en cycle) and during GAP
    req = 4'b0100;
    wait_en(n);
    req = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_wa_en", en, 1'b0);
    check_eq("t6_wa_grant", grant, 4'b0000);
    check_eq("t6_wa_data", data, 4'h0);
    check_eq("t6_wa_busy", busy, 1'b0);
    step();
    rst_n = 1'b1;
    gap = 8'd5;
    req = 4'b0001;
    wait_en(n);
    req = 4'b0000;
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    check_eq("t6_in_gap", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_gap_busy", busy, 1'b0);
    check_eq("t6_gap_data", data, 4'h0);
    check_eq("t6_gap_en", en, 1'b0);
    step();
    rst_n = 1'b1;
    gap = 8'd0;
    req = 4'b0010;
    wait_en(n);
    check_eq("t6_rel_lat", 32'(n), 32'd1);
    check_eq("t6_rel_grant", grant, 4'b0010);
    check_eq("t6_rel_data", data, 4'hB);
    close_xfer();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cdc_send_arbiter.md
# cdc_send_arbiter

Source-domain controller that shares one CDC sender channel (4-bit `data`, single-cycle `en` strobe, `ack` feedback pulse from the receiving side) among several local requesters. It selects requesters round-robin, issues one transfer at a time, and holds the channel closed until the synchronized `ack` returns. It then enforces a programmable idle gap before the next transfer. A watchdog releases the channel if `ack` never arrives. Sits between the source-side producers and the pulse/handshake synchronizer of the added-feedback CDC path.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 4: payload width.
- `TMO_W`, 8: width of the ack-timeout counter.

Ports:
- `clk` input 1: single clock. All logic is in this domain.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `req` input N_REQ: per-requester request level. Held high until the matching `grant`.
- `req_data` input N_REQ*DATA_W: per-requester payload. Requester i uses bits [i*DATA_W +: DATA_W], which must be stable while `req[i]` is high.
- `grant` output N_REQ: one-hot, single-cycle pulse marking the requester whose payload is launched this cycle.
- `data` output DATA_W: payload to the synchronizer. Held stable from the `en` cycle until the channel leaves WAIT_ACK.
- `en` output 1: single-cycle transfer strobe.
- `ack` input 1: receiver acknowledge, already synchronized into `clk`. Treated as a pulse.
- `gap` input 8: minimum idle cycles after `ack` before the next `en`. Sampled when `ack` is accepted.
- `tmo_limit` input TMO_W: WAIT_ACK cycles before timeout. A value of 0 disables the watchdog.
- `busy` output 1: high in every state except IDLE.
- `tmo_err` output 1: single-cycle pulse on watchdog expiry.

## Operation

- FSM states: IDLE, WAIT_ACK, GAP.
- IDLE with any `req` bit high:
  - select the first requester at or after the round-robin pointer `rr_ptr`, scanning upward with wrap-around;
  - next cycle: `en`=1, `grant[sel]`=1, `data` = that requester's payload, state goes to WAIT_ACK;
  - `rr_ptr` moves to sel+1, mod N_REQ.
- WAIT_ACK:
  - `ack`=1: capture `gap` into the gap counter, clear the timeout counter, go to GAP. If the captured gap is 0, go directly to IDLE.
  - `ack`=0 with `tmo_limit`≠0: increment the timeout counter. When it reaches `tmo_limit`, pulse `tmo_err` and go to IDLE. The transfer counts as consumed and is not retried.
- GAP: decrement the gap counter each cycle. Leave for IDLE on the cycle the counter reaches 0.
- `ack` is ignored in IDLE, in GAP, and in the `en` cycle itself. A late `ack` after a timeout therefore has no effect.
- `data` holds its last value in IDLE and GAP. It never changes while `en`=1 or during WAIT_ACK.
- `req` dropped before grant means that requester is simply not selected. There is no error.

## Timing

- Reset (`rst_n`=0, asynchronous): state=IDLE, `en`=0, `grant`=0, `data`=0, `busy`=0, `tmo_err`=0, `rr_ptr`=0, all counters 0.
- Reset mid-transfer aborts immediately. No `grant` or `en` may appear until after release.
- Latency from `req` rising in IDLE to the `en`/`grant` pulse: 1 cycle (registered).
- `en` and `grant` are coincident and exactly 1 cycle wide. At most one `en` is outstanding at a time.
- `ack` sampled at cycle t in WAIT_ACK: the earliest next `en` is at cycle t+gap+2 (1 cycle of GAP exit, 1 cycle of IDLE arbitration).
- Timeout: with `en` at cycle e and no `ack`, `tmo_err` pulses at cycle e+`tmo_limit`. The earliest next `en` is then at e+`tmo_limit`+2.
- `ack` and timeout expiry in the same cycle: `ack` wins and `tmo_err` stays 0.
- `busy` rises with `en` and falls on the first IDLE cycle.

## Test plan

- Single requester, `gap`=3, `ack` returned 5 cycles after `en`, payload 0x7: observe `en`=1 with `data`=0x7 and `grant`=0001. The next `en` comes exactly 3+2 cycles after `ack`.
- All 4 requesters held high, `gap`=0, `ack` 2 cycles after each `en`: the grant order is 0,1,2,3,0 with no repeats while the others are pending.
- `rr_ptr`=3 with only req[1] high: grant goes to requester 1 and `rr_ptr` becomes 2. Then raise req[0] and req[2] together: the grant goes to 2.
- `tmo_limit`=10 and `ack` never sent: `tmo_err` pulses 10 cycles after `en`, and `busy` drops. An `ack` injected 3 cycles later produces no state change. The next pending request is granted normally.
- `tmo_limit`=4 with `ack` arriving exactly on the expiry cycle: `tmo_err` stays 0 and the FSM enters GAP.
- Assert `rst_n`=0 during WAIT_ACK and during GAP: all outputs are 0 asynchronously. After release with req=0010, the first `en` carries requester 1's data and `grant`=0010.
